div_sqrt_iter_seq_mvp: RTL and testbench



---
 rtl/div_sqrt_iter_pkg.sv | 14 +
 rtl/div_sqrt_step_mvp.sv | 46 ++++
 rtl/div_sqrt_iter_seq_mvp.sv | 129 ++++++++++++
 tb/tb_div_sqrt_iter_seq_mvp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sqrt_iter_pkg.sv
// Shared types and sizing helpers for the iterative div/sqrt mantissa engine.
package div_sqrt_iter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  // Result carries two bits beyond the mantissa; the remainder needs two more than the result.
  localparam int unsigned RES_EXTRA_W = 2;
  localparam int unsigned REM_EXTRA_W = 4;

  function automatic int unsigned num_iter_cycles(input int unsigned width, input int unsigned k);
    return (width + RES_EXTRA_W + k - 1) / k;
  endfunction

endpackage

// File: rtl/div_sqrt_step_mvp.sv
// One combinational restoring radix-2 step, shared by divide and square root.
module div_sqrt_step_mvp
  import div_sqrt_iter_pkg::*;
#(
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned N     = WIDTH + RES_EXTRA_W,
  localparam int unsigned REM_W = WIDTH + REM_EXTRA_W
) (
  input  logic             i_sqrt,
  input  logic             i_en,
  input  logic [REM_W-1:0] i_rem,
  input  logic [N-1:0]     i_root,
  input  logic [1:0]       i_rad2,
  input  logic [WIDTH-1:0] i_div,
  output logic [REM_W-1:0] o_rem,
  output logic [N-1:0]     o_root
);

  logic [REM_W-1:0] w_div_ext;
  logic [REM_W-1:0] w_div_dif;
  logic [REM_W-1:0] w_div_rem;
  logic             w_div_ge;
  logic [REM_W+1:0] w_sq_sh;
  logic [REM_W+1:0] w_sq_trial;
  logic [REM_W-1:0] w_sq_dif;
  logic [REM_W-1:0] w_sq_rem;
  logic             w_sq_ge;
  logic             w_bit;

  assign w_div_ext = {{(REM_W-WIDTH){1'b0}}, i_div};
  assign w_div_ge  = (i_rem >= w_div_ext);
  assign w_div_dif = i_rem - w_div_ext;
  assign w_div_rem = (w_div_ge ? w_div_dif : i_rem) << 1;

  // Sqrt trial subtrahend is 4*Q+1; the kept remainder always fits REM_W bits.
  assign w_sq_sh    = {i_rem, i_rad2};
  assign w_sq_trial = {2'b00, i_root, 2'b01};
  assign w_sq_ge    = (w_sq_sh >= w_sq_trial);
  assign w_sq_dif   = w_sq_sh[REM_W-1:0] - w_sq_trial[REM_W-1:0];
  assign w_sq_rem   = w_sq_ge ? w_sq_dif : w_sq_sh[REM_W-1:0];

  assign w_bit  = i_sqrt ? w_sq_ge : w_div_ge;
  assign o_rem  = !i_en ? i_rem : (i_sqrt ? w_sq_rem : w_div_rem);
  assign o_root = i_en ? {i_root[N-2:0], w_bit} : i_root;

endmodule

// File: rtl/div_sqrt_iter_seq_mvp.sv
// Multi-cycle restoring div/sqrt mantissa engine, ITER_PER_CYCLE steps per clock.
// Optional early termination on zero remainder: define DIV_SQRT_EARLY_TERM_EN.
module div_sqrt_iter_seq_mvp
  import div_sqrt_iter_pkg::*;
#(
  parameter  int unsigned WIDTH          = 24,
  parameter  int unsigned ITER_PER_CYCLE = 2,
  localparam int unsigned N              = WIDTH + RES_EXTRA_W
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Start_SI,
  input  logic             Sqrt_SI,
  input  logic             Odd_SI,
  input  logic [WIDTH-1:0] A_DI,
  input  logic [WIDTH-1:0] B_DI,
  input  logic             Kill_SI,
  output logic             Ready_SO,
  output logic             Valid_SO,
  input  logic             Out_ready_SI,
  output logic [N-1:0]     Result_DO,
  output logic             Sticky_SO
);

  localparam int unsigned REM_W = WIDTH + REM_EXTRA_W;
  localparam int unsigned C     = num_iter_cycles(WIDTH, ITER_PER_CYCLE);
  localparam int unsigned CNT_W = $clog2(C + 1);
  localparam int unsigned RAD_W = 2 * N;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sqrt;
  logic [WIDTH-1:0] r_b;
  logic [RAD_W-1:0] r_rad, w_rad_nxt, w_rad_init;
  logic [REM_W-1:0] r_rem;
  logic [N-1:0]     r_res, w_res_nxt;
  logic             r_sticky;
  logic [REM_W-1:0] w_rem  [ITER_PER_CYCLE+1];
  logic [N-1:0]     w_root [ITER_PER_CYCLE+1];
  logic             w_last, w_early, w_accept, w_step;

  assign w_rem[0]  = r_rem;
  assign w_root[0] = r_res;

  // Steps beyond the N-th result bit are bypassed in the final cycle.
  for (genvar k = 0; k < ITER_PER_CYCLE; k++) begin : g_step
    localparam int unsigned KK = k;
    logic w_en;
    assign w_en = ((32'(r_cnt) * ITER_PER_CYCLE) + KK) < N;
    div_sqrt_step_mvp #(.WIDTH(WIDTH)) u_step (
      .i_sqrt (r_sqrt),
      .i_en   (w_en),
      .i_rem  (w_rem[k]),
      .i_root (w_root[k]),
      .i_rad2 (r_rad[RAD_W-1-2*k -: 2]),
      .i_div  (r_b),
      .o_rem  (w_rem[k+1]),
      .o_root (w_root[k+1])
    );
  end

  assign w_rad_nxt  = r_rad << (2 * ITER_PER_CYCLE);
  assign w_rad_init = Odd_SI ? ({{(RAD_W-WIDTH){1'b0}}, A_DI} << (WIDTH + 4))
                             : ({{(RAD_W-WIDTH){1'b0}}, A_DI} << (WIDTH + 3));
  assign w_last     = (r_cnt == CNT_W'(C - 1));
  assign w_accept   = (r_state == ST_IDLE) && Start_SI && !Kill_SI;
  assign w_step     = (r_state == ST_BUSY) && !Kill_SI;

`ifdef DIV_SQRT_EARLY_TERM_EN
  // Sqrt also needs the unconsumed radicand to be zero before the remaining bits are known zero.
  logic [31:0] w_done_steps;
  assign w_done_steps = (32'(r_cnt) + 32'd1) * ITER_PER_CYCLE;
  assign w_early      = (w_rem[ITER_PER_CYCLE] == '0) && (w_rad_nxt == '0);
  assign w_res_nxt    = (w_early && (w_done_steps < N))
                        ? (w_root[ITER_PER_CYCLE] << (N - w_done_steps))
                        : w_root[ITER_PER_CYCLE];
`else
  assign w_early   = 1'b0;
  assign w_res_nxt = w_root[ITER_PER_CYCLE];
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (Start_SI)             w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last || w_early)    w_state_nxt = ST_DONE;
      ST_DONE: if (Out_ready_SI)         w_state_nxt = ST_IDLE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
    if (Kill_SI) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_res    <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= '0;
        r_res <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        r_res <= w_res_nxt;
        if (w_last || w_early) r_sticky <= |w_rem[ITER_PER_CYCLE];
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (w_accept) begin
      r_sqrt <= Sqrt_SI;
      r_b    <= B_DI;
      r_rem  <= Sqrt_SI ? '0 : {{(REM_W-WIDTH){1'b0}}, A_DI};
      r_rad  <= Sqrt_SI ? w_rad_init : '0;
    end else if (w_step) begin
      r_rem <= w_rem[ITER_PER_CYCLE];
      r_rad <= w_rad_nxt;
    end
  end

  assign Ready_SO  = (r_state == ST_IDLE);
  assign Valid_SO  = (r_state == ST_DONE);
  assign Result_DO = r_res;
  assign Sticky_SO = r_sticky;

endmodule

// File: tb/tb_div_sqrt_iter_seq_mvp.sv
// Directed-vector and random bench for div_sqrt_iter_seq_mvp (ITER_PER_CYCLE 1..4).
module tb_div_sqrt_iter_seq_mvp;

  logic        clk = 1'b0;
  logic        rst_n, start, sqrt, odd, kill, out_ready;
  logic [23:0] a, b;
  logic [3:0]  rdy_v, vld_v, st_v;
  logic [3:0][25:0] res_v;
  int checks = 0;
  int failures = 0;
  int cs [4] = '{13, 26, 9, 7};

  always #5 clk = ~clk;

  div_sqrt_iter_seq_mvp #(.WIDTH(24), .ITER_PER_CYCLE(2)) u_dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Sqrt_SI(sqrt), .Odd_SI(odd),
    .A_DI(a), .B_DI(b), .Kill_SI(kill), .Ready_SO(rdy_v[0]), .Valid_SO(vld_v[0]),
    .Out_ready_SI(out_ready), .Result_DO(res_v[0]), .Sticky_SO(st_v[0]));
  div_sqrt_iter_seq_mvp #(.WIDTH(24), .ITER_PER_CYCLE(1)) u_k1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Sqrt_SI(sqrt), .Odd_SI(odd),
    .A_DI(a), .B_DI(b), .Kill_SI(1'b0), .Ready_SO(rdy_v[1]), .Valid_SO(vld_v[1]),
    .Out_ready_SI(1'b1), .Result_DO(res_v[1]), .Sticky_SO(st_v[1]));
  div_sqrt_iter_seq_mvp #(.WIDTH(24), .ITER_PER_CYCLE(3)) u_k3 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Sqrt_SI(sqrt), .Odd_SI(odd),
    .A_DI(a), .B_DI(b), .Kill_SI(1'b0), .Ready_SO(rdy_v[2]), .Valid_SO(vld_v[2]),
    .Out_ready_SI(1'b1), .Result_DO(res_v[2]), .Sticky_SO(st_v[2]));
  div_sqrt_iter_seq_mvp #(.WIDTH(24), .ITER_PER_CYCLE(4)) u_k4 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Sqrt_SI(sqrt), .Odd_SI(odd),
    .A_DI(a), .B_DI(b), .Kill_SI(1'b0), .Ready_SO(rdy_v[3]), .Valid_SO(vld_v[3]),
    .Out_ready_SI(1'b1), .Result_DO(res_v[3]), .Sticky_SO(st_v[3]));

  typedef struct {
    bit          sq;
    bit          od;
    logic [23:0] a;
    logic [23:0] b;
    logic [25:0] res;
    bit          st;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int lat, input int c);
`ifdef DIV_SQRT_EARLY_TERM_EN
    checks++;
    if (lat < 1 || lat > c) begin
      failures++;
      $display("FAIL %s latency=%0d required=1..%0d", name, lat, c);
    end
`else
    chk(name, 64'(lat), 64'(c));
`endif
  endtask

  // Integer reference: long division and bitwise integer square root.
  function automatic void model(input bit sq, input bit od, input logic [23:0] ia,
                                input logic [23:0] ib, output logic [25:0] q, output bit st);
    logic [63:0] x, qq, t;
    if (!sq) begin
      x  = {40'd0, ia} << 25;
      qq = x / {40'd0, ib};
      st = (x % {40'd0, ib}) != 64'd0;
    end else begin
      x  = {40'd0, ia} << (27 + od);
      qq = 64'd0;
      for (int i = 25; i >= 0; i--) begin
        t = qq | (64'd1 << i);
        if (t * t <= x) qq = t;
      end
      st = (qq * qq) != x;
    end
    q = qq[25:0];
  endfunction

  task automatic wait_all_ready(input string name);
    int n = 0;
    while (rdy_v != 4'hF && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(rdy_v), 64'hF);
  endtask

  task automatic run_op(input bit sq, input bit od, input logic [23:0] ia, input logic [23:0] ib,
                        output int lat, output logic rdy_acc, output logic [25:0] r, output logic st);
    sqrt = sq; odd = od; a = ia; b = ib; start = 1'b1;
    tick();
    start   = 1'b0;
    rdy_acc = rdy_v[0];
    lat     = 0;
    while (!vld_v[0] && lat < 40) begin
      tick();
      lat++;
    end
    r  = res_v[0];
    st = st_v[0];
  endtask

  initial begin
    int          lat, seen, cyc;
    logic        rdy_acc, st;
    logic [25:0] r, exp_q;
    bit          exp_st;
    bit          got [4];
    logic [25:0] gr [4];
    logic        gs [4];
    int          gl [4];
    bit          rs, ro;
    logic [23:0] ra, rb;

    vecs[0] = '{sq: 1'b0, od: 1'b0, a: 24'hC00000, b: 24'h800000, res: 26'h3000000, st: 1'b0};
    vecs[1] = '{sq: 1'b0, od: 1'b0, a: 24'h800000, b: 24'hC00000, res: 26'h1555555, st: 1'b1};
    vecs[2] = '{sq: 1'b1, od: 1'b0, a: 24'h800000, b: 24'h000000, res: 26'h2000000, st: 1'b0};
    vecs[3] = '{sq: 1'b1, od: 1'b1, a: 24'h800000, b: 24'h000000, res: 26'h2D413CC, st: 1'b1};
    vecs[4] = '{sq: 1'b0, od: 1'b0, a: 24'hFFFFFF, b: 24'hFFFFFF, res: 26'h2000000, st: 1'b0};
    vecs[5] = '{sq: 1'b0, od: 1'b0, a: 24'hFFFFFF, b: 24'h800000, res: 26'h3FFFFFC, st: 1'b0};

    rst_n = 1'b0; start = 1'b0; sqrt = 1'b0; odd = 1'b0; kill = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;
    tick();
    tick();
    chk("reset_ready", 64'(rdy_v[0]), 64'd1);
    chk("reset_valid", 64'(vld_v[0]), 64'd0);
    chk("reset_result", 64'(res_v[0]), 64'd0);
    chk("reset_sticky", 64'(st_v[0]), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      wait_all_ready($sformatf("vec%0d_ready", i));
      run_op(vecs[i].sq, vecs[i].od, vecs[i].a, vecs[i].b, lat, rdy_acc, r, st);
      chk($sformatf("vec%0d_ready_fall", i), 64'(rdy_acc), 64'd0);
      chk_lat($sformatf("vec%0d_latency", i), lat, 13);
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
      chk($sformatf("vec%0d_sticky", i), 64'(st), 64'(vecs[i].st));
      tick();
      chk($sformatf("vec%0d_ready_after", i), 64'(rdy_v[0]), 64'd1);
      chk($sformatf("vec%0d_valid_after", i), 64'(vld_v[0]), 64'd0);
    end
    // Divide 0x800000/0xC00000 never has a zero remainder, so it runs the full 13 edges.
    wait_all_ready("lat13_ready");
    run_op(1'b0, 1'b0, 24'h800000, 24'hC00000, lat, rdy_acc, r, st);
    chk("lat13_exact", 64'(lat), 64'd13);
    tick();

    // Backpressure with start pulses while the result waits.
    wait_all_ready("bp_ready");
    out_ready = 1'b0;
    run_op(1'b0, 1'b0, 24'hC00000, 24'h800000, lat, rdy_acc, r, st);
    chk("bp_result", 64'(r), 64'h3000000);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2) == 0;
      a = 24'h800000; b = 24'hC00000;
      tick();
      chk($sformatf("bp_valid_%0d", i), 64'(vld_v[0]), 64'd1);
      chk($sformatf("bp_ready_%0d", i), 64'(rdy_v[0]), 64'd0);
      chk($sformatf("bp_hold_%0d", i), 64'(res_v[0]), 64'h3000000);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_consume_ready", 64'(rdy_v[0]), 64'd1);
    chk("bp_consume_valid", 64'(vld_v[0]), 64'd0);

    // Abort on the 5th BUSY edge, first by kill, then by reset.
    for (int mode = 0; mode < 2; mode++) begin
      wait_all_ready($sformatf("abort%0d_ready", mode));
      sqrt = 1'b0; odd = 1'b0; a = 24'h800000; b = 24'hC00000; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      if (mode == 0) kill = 1'b1;
      else rst_n = 1'b0;
      tick();
      chk($sformatf("abort%0d_ready", mode), 64'(rdy_v[0]), 64'd1);
      chk($sformatf("abort%0d_valid", mode), 64'(vld_v[0]), 64'd0);
      if (mode == 1) begin
        chk("abort1_result_reset", 64'(res_v[0]), 64'd0);
        chk("abort1_sticky_reset", 64'(st_v[0]), 64'd0);
      end
      kill = 1'b0;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (vld_v[0]) seen = 1;
      end
      chk($sformatf("abort%0d_no_valid", mode), 64'(seen), 64'd0);
      wait_all_ready($sformatf("abort%0d_new_ready", mode));
      run_op(1'b0, 1'b0, 24'hC00000, 24'h800000, lat, rdy_acc, r, st);
      chk_lat($sformatf("abort%0d_new_latency", mode), lat, 13);
      chk($sformatf("abort%0d_new_result", mode), 64'(r), 64'h3000000);
      chk($sformatf("abort%0d_new_sticky", mode), 64'(st), 64'd0);
      tick();
    end

    // Random normalised operands across all unroll factors.
    for (int n = 0; n < 300; n++) begin
      wait_all_ready("rnd_ready");
      rs = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      ra = {1'b1, 23'($urandom)};
      rb = {1'b1, 23'($urandom)};
      sqrt = rs; odd = ro; a = ra; b = rb; start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < 4; j++) got[j] = 1'b0;
      cyc = 0;
      while (cyc < 40) begin
        for (int j = 0; j < 4; j++) begin
          if (!got[j] && vld_v[j]) begin
            got[j] = 1'b1; gr[j] = res_v[j]; gs[j] = st_v[j]; gl[j] = cyc;
          end
        end
        if (got[0] && got[1] && got[2] && got[3]) break;
        tick();
        cyc++;
      end
      model(rs, ro, ra, rb, exp_q, exp_st);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("rnd%0d_inst%0d_valid", n, j), 64'(got[j]), 64'd1);
        chk($sformatf("rnd%0d_inst%0d_result", n, j), 64'(gr[j]), 64'(exp_q));
        chk($sformatf("rnd%0d_inst%0d_sticky", n, j), 64'(gs[j]), 64'(exp_st));
        chk_lat($sformatf("rnd%0d_inst%0d_latency", n, j), gl[j], cs[j]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
